// File: rtl/bp_pkg.sv
// Shared types for the branch resolve unit: widths, the in-flight entry payload
// and the occupancy state encoding.
package bp_pkg;

   localparam int unsigned GHR_WIDTH_DEFAULT = 8;
   localparam int unsigned INDEX_WIDTH       = 8;
   localparam int unsigned PC_WIDTH          = 32;

   // One predicted branch awaiting resolution; ghr is the history the predictor used.
   typedef struct packed {
      logic [PC_WIDTH-1:0]          pc;
      logic                         taken;
      logic [INDEX_WIDTH-1:0]       index;
      logic [GHR_WIDTH_DEFAULT-1:0] ghr;
   } inflight_entry_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_BUSY  = 1'b1
   } occ_state_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Predictor/execute-side bundle of the branch resolve unit.
// The master drives predictions and resolutions; the slave is the unit itself.
interface branch_resolve_unit_if
   import bp_pkg::*;
#(
   parameter int unsigned GHR_WIDTH = GHR_WIDTH_DEFAULT,
   parameter int unsigned DEPTH     = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic                   pred_valid;
   logic                   pred_ready;
   logic [PC_WIDTH-1:0]    pred_pc;
   logic                   pred_taken;
   logic [INDEX_WIDTH-1:0] pred_index;
   logic [GHR_WIDTH-1:0]   pred_ghr;
   logic                   exec_valid;
   logic                   exec_taken;
   logic                   branch_resolved;
   logic                   branch_taken;
   logic [PC_WIDTH-1:0]    resolved_pc;
   logic [INDEX_WIDTH-1:0] resolved_index;
   logic                   mispredict;
   logic [GHR_WIDTH-1:0]   restore_ghr;
   logic [CNT_W-1:0]       inflight_count;
   logic                   err_underflow;

   modport master (
      output pred_valid, pred_pc, pred_taken, pred_index, pred_ghr, exec_valid, exec_taken,
      input  pred_ready, branch_resolved, branch_taken, resolved_pc, resolved_index,
             mispredict, restore_ghr, inflight_count, err_underflow
   );

   modport slave (
      input  pred_valid, pred_pc, pred_taken, pred_index, pred_ghr, exec_valid, exec_taken,
      output pred_ready, branch_resolved, branch_taken, resolved_pc, resolved_index,
             mispredict, restore_ghr, inflight_count, err_underflow
   );

endinterface

// File: rtl/bp_inflight_fifo.sv
// Circular queue of in-flight predicted branches with push, pop and flush.
// A flush always accompanies a pop of the head and discards everything younger.
module bp_inflight_fifo
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  inflight_entry_t         wr_data,
   output inflight_entry_t         head,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   inflight_entry_t  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign head = mem[rd_ptr];

   // Storage is never reset; only entries between the pointers are meaningful.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= rd_ptr + PTR_W'(1);
         wr_ptr <= rd_ptr + PTR_W'(1);
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks predicted branches in order and resolves them against execute results,
// reporting updates, mispredicts and the repaired global history to the predictor.
module branch_resolve_unit
   import bp_pkg::*;
#(
   parameter int unsigned GHR_WIDTH = GHR_WIDTH_DEFAULT,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   branch_resolve_unit_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   occ_state_t       state;
   inflight_entry_t  head;
   inflight_entry_t  wr_entry;
   logic [CNT_W-1:0] count;
   logic             push_c;
   logic             pop_c;
   logic             mispredict_c;

   assign bus.pred_ready     = (count != CNT_W'(DEPTH));
   assign bus.inflight_count = count;

   assign push_c       = bus.pred_valid && bus.pred_ready;
   assign pop_c        = bus.exec_valid && (state == ST_BUSY);
   assign mispredict_c = pop_c && (bus.exec_taken != head.taken);

   assign wr_entry.pc    = bus.pred_pc;
   assign wr_entry.taken = bus.pred_taken;
   assign wr_entry.index = bus.pred_index;
   assign wr_entry.ghr   = GHR_WIDTH_DEFAULT'(bus.pred_ghr);

   bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_c),
      .pop     (pop_c),
      .flush   (mispredict_c),
      .wr_data (wr_entry),
      .head    (head),
      .count   (count)
   );

   // Occupancy FSM; a mispredict empties the queue and drops any same-cycle push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: if (push_c) state <= ST_BUSY;
            ST_BUSY:  if (mispredict_c || (pop_c && !push_c && count == CNT_W'(1)))
                         state <= ST_EMPTY;
            default:  state <= ST_EMPTY;
         endcase
      end
   end

   // Resolution outputs; direction, pc, index and history hold between resolutions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.branch_resolved <= 1'b0;
         bus.branch_taken    <= 1'b0;
         bus.resolved_pc     <= '0;
         bus.resolved_index  <= '0;
         bus.mispredict      <= 1'b0;
         bus.restore_ghr     <= '0;
         bus.err_underflow   <= 1'b0;
      end else begin
         bus.branch_resolved <= pop_c;
         bus.mispredict      <= mispredict_c;
         if (pop_c) begin
            bus.branch_taken   <= bus.exec_taken;
            bus.resolved_pc    <= head.pc;
            bus.resolved_index <= head.index;
         end
         if (mispredict_c) begin
            bus.restore_ghr <= GHR_WIDTH'({head.ghr, bus.exec_taken});
         end
         if (bus.exec_valid && state == ST_EMPTY) begin
            bus.err_underflow <= 1'b1;
         end
      end
   end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter GHR_WIDTH, default 8, meaning global history width, matching the predictor.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the maximum number of in-flight predicted branches; power of 2, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port pred_valid, input, 1 bit: a new prediction is offered.
REQ-006 SHALL have port pred_ready, output, 1 bit: the unit can accept a prediction; equals count != DEPTH (combinational).
REQ-007 SHALL have ports pred_pc (input, 32 bits), pred_taken (input, 1 bit), pred_index (input, 8 bits) and pred_ghr (input, GHR_WIDTH bits): the predictor's outputs for the offered branch.
REQ-008 SHALL have port exec_valid, input, 1 bit: the execute stage resolves the oldest in-flight branch.
REQ-009 SHALL have port exec_taken, input, 1 bit: the actual direction of that branch.
REQ-010 SHALL have ports branch_resolved (output, 1 bit), branch_taken (output, 1 bit) and resolved_pc (output, 32 bits): the update interface back to the predictor.
REQ-011 SHALL have port resolved_index, output, 8 bits: the PHT index of the resolved branch.
REQ-012 SHALL have port mispredict, output, 1 bit: the resolved direction differed from the prediction.
REQ-013 SHALL have port restore_ghr, output, GHR_WIDTH bits: the corrected history, valid while mispredict=1.
REQ-014 SHALL have port inflight_count, output, $clog2(DEPTH)+1 bits: the current number of queued entries.
REQ-015 SHALL have port err_underflow, output, 1 bit: sticky flag set when exec_valid arrives with the queue empty.

Function
REQ-016 SHALL store each accepted prediction {pc, taken, index, ghr} in a circular FIFO; a push occurs when pred_valid && pred_ready.
REQ-017 SHALL resolve strictly in order: exec_valid pops the head entry when count > 0.
REQ-018 SHALL register all resolution outputs; outputs appear exactly 1 cycle after the exec_valid edge.
REQ-019 SHALL pulse branch_resolved for exactly 1 cycle per pop, with branch_taken=exec_taken and resolved_pc/resolved_index taken from the head entry.
REQ-020 SHALL assert mispredict together with branch_resolved when exec_taken != head.taken.
REQ-021 SHALL drive restore_ghr = {head.ghr[GHR_WIDTH-2:0], exec_taken} on a mispredict and hold it otherwise.
REQ-022 SHALL, on a mispredict, flush all younger entries: count <= 0 and wr_ptr <= rd_ptr+1 (the head after the pop).
REQ-023 SHALL give the flush priority over a same-cycle push; that push is dropped as wrong-path, and pred_ready does not change that cycle.
REQ-024 SHALL, on a correct-prediction pop with a simultaneous push, apply both and leave count unchanged.
REQ-025 SHALL refuse pushes when full; a same-cycle pop does not make pred_ready high within that cycle.
REQ-026 SHALL wrap pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-027 SHALL treat exec_valid with count=0 as follows: no pulse, err_underflow <= 1 until reset, no other state change.
REQ-028 SHALL run a two-state FSM on occupancy: EMPTY (count=0) and BUSY (count>0); EMPTY->BUSY on push; BUSY->EMPTY on a flush or on popping the last entry without a push.

Reset
REQ-029 SHALL, when reset is asserted, asynchronously clear pointers, count, FSM (to EMPTY), branch_resolved, branch_taken, mispredict, resolved_pc, resolved_index, restore_ghr and err_underflow to 0; pred_ready becomes 1.
REQ-030 SHALL, on reset during operation, discard all in-flight entries with no resolution pulse.
REQ-031 SHALL not require the FIFO storage array to be reset.

Structure
REQ-032 SHALL place the GHR_WIDTH default, the index width (8) and a packed in-flight entry struct in a shared package, bp_pkg.
REQ-033 SHALL implement the storage as one sub-module, bp_inflight_fifo (push/pop/flush, count), with resolution and compare logic in the top level.

Verification
REQ-034 SHALL verify correct prediction: push pc=0x40, taken=1, ghr=0x00; then exec_taken=1 -> one cycle later branch_resolved=1, mispredict=0, resolved_pc=0x40, count=0.
REQ-035 SHALL verify mispredict flush: push three entries (first ghr=0x5A, taken=0); exec_taken=1 -> mispredict=1, restore_ghr=0xB5, count=0.
REQ-036 SHALL verify full: push 4 entries -> pred_ready=0; a 5th push is ignored; then pop all 4 in order with the correct pcs.
REQ-037 SHALL verify push dropped on a flush: mispredicting pop plus push in the same cycle -> count=0 and the pushed pc is never resolved.
REQ-038 SHALL verify underflow: exec_valid with empty queue -> no branch_resolved pulse, err_underflow=1 until reset.
REQ-039 SHALL verify async reset: assert reset between clock edges with 2 entries in flight -> outputs 0 immediately, count=0, pred_ready=1.
